alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer implementing RV32M MUL/DIV/DIVU/REM/REMU.
- Does not instantiate its own adder. It borrows the core's shared execute ALU through an operand/op-select mux port, issuing one ADD or SUB per cycle.
- Sits beside the execute stage. The core holds the instruction stalled until the response handshake completes.

---
 rtl/alu_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer.
// Borrows the core's shared execute ALU for one ADD or SUB per cycle instead of owning an adder.
module alu_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_illegal_o,
    output logic            alu_busy_o,
    output logic [XLEN-1:0] alu_opr_a_o,
    output logic [XLEN-1:0] alu_opr_b_o,
    output logic [3:0]      alu_op_sel_o,
    input  logic [XLEN-1:0] alu_res_i
);
    localparam logic [3:0]      ALU_ADD = 4'b0000;
    localparam logic [3:0]      ALU_SUB = 4'b1000;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIXUP,
        DONE
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             req_mul, req_illegal, req_rem, req_signed;
    logic             a_neg, b_neg, need_neg, special;
    logic [XLEN-1:0]  a_abs, b_abs, special_data;

    logic             is_mul, is_rem, neg, illegal_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc, mcand, mplier;
    logic [XLEN-1:0]  rem, dvd, divisor, quo;
    logic [XLEN-1:0]  result;

    logic [XLEN-1:0]  rs, iter_result;
    logic             take, last_iter;

    assign req_ready_o    = (state == IDLE);
    assign resp_valid_o   = (state == DONE);
    assign resp_data_o    = resp_valid_o ? result : '0;
    assign resp_illegal_o = resp_valid_o & illegal_q;
    assign accept         = req_valid_i & req_ready_o & ~flush_i;

    // Request decode: operand magnitudes, result sign and the cases that bypass iteration.
    always_comb begin
        req_mul      = (req_op_i == 3'b000);
        req_illegal  = ~req_op_i[2] & (req_op_i[1:0] != 2'b00);
        req_rem      = req_op_i[2] & req_op_i[1];
        req_signed   = req_op_i[2] & ~req_op_i[0];
        a_neg        = req_signed & req_a_i[XLEN-1];
        b_neg        = req_signed & req_b_i[XLEN-1];
        a_abs        = a_neg ? -req_a_i : req_a_i;
        b_abs        = b_neg ? -req_b_i : req_b_i;
        need_neg     = req_rem ? a_neg : (a_neg ^ b_neg);
        special      = 1'b0;
        special_data = '0;
        if (req_illegal) begin
            special = 1'b1;
        end else if (req_op_i[2] && (req_b_i == '0)) begin
            special      = 1'b1;
            special_data = req_rem ? req_a_i : '1;
        end else if (req_signed && (req_a_i == MIN_NEG) && (req_b_i == '1)) begin
            special      = 1'b1;
            special_data = req_rem ? '0 : MIN_NEG;
        end
    end

    // One restoring-division / shift-add step; rem[XLEN-1] marks a shifted remainder past XLEN bits.
    always_comb begin
        rs        = {rem[XLEN-2:0], dvd[XLEN-1]};
        take      = rem[XLEN-1] | (rs >= divisor);
        last_iter = (cnt == CNT_W'(XLEN-1));
        if (is_mul) begin
            iter_result = mplier[0] ? alu_res_i : acc;
        end else if (is_rem) begin
            iter_result = take ? alu_res_i : rs;
        end else begin
            iter_result = {quo[XLEN-2:0], take};
        end
    end

    always_comb begin
        alu_busy_o   = 1'b0;
        alu_opr_a_o  = '0;
        alu_opr_b_o  = '0;
        alu_op_sel_o = ALU_ADD;
        case (state)
            ITER: begin
                alu_busy_o = 1'b1;
                if (is_mul) begin
                    alu_opr_a_o = acc;
                    alu_opr_b_o = mcand;
                end else begin
                    alu_opr_a_o  = rs;
                    alu_opr_b_o  = divisor;
                    alu_op_sel_o = ALU_SUB;
                end
            end
            FIXUP: begin
                alu_busy_o   = 1'b1;
                alu_opr_b_o  = result;
                alu_op_sel_o = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every other transition, including the response handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : ITER;
            ITER:    if (last_iter) state_next = neg ? FIXUP : DONE;
            FIXUP:   state_next = DONE;
            DONE:    if (resp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_mul    <= 1'b0;
            is_rem    <= 1'b0;
            neg       <= 1'b0;
            illegal_q <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            dvd       <= '0;
            divisor   <= '0;
            quo       <= '0;
            result    <= '0;
        end else if (accept) begin
            is_mul    <= req_mul;
            is_rem    <= req_rem;
            neg       <= need_neg & ~special;
            illegal_q <= req_illegal;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= req_a_i;
            mplier    <= req_b_i;
            rem       <= '0;
            dvd       <= a_abs;
            divisor   <= b_abs;
            quo       <= '0;
            result    <= special_data;
        end else if (state == ITER) begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul) begin
                if (mplier[0]) acc <= alu_res_i;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                rem <= take ? alu_res_i : rs;
                quo <= {quo[XLEN-2:0], take};
                dvd <= dvd << 1;
            end
            if (last_iter) result <= iter_result;
        end else if (state == FIXUP) begin
            result <= alu_res_i;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed corner cases plus random ops against an arithmetic reference model.
module tb_alu_muldiv_seq;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_illegal;
    logic        alu_busy;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_sel;

    int checks = 0;
    int fails  = 0;

    logic [2:0] op_list [5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

    always #5 clk = ~clk;

    // Stand-in for the core's shared execute ALU.
    assign alu_res = (alu_sel == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    alu_muldiv_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .flush_i       (flush),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .resp_illegal_o(resp_illegal),
        .alu_busy_o    (alu_busy),
        .alu_opr_a_o   (alu_a),
        .alu_opr_b_o   (alu_b),
        .alu_op_sel_o  (alu_sel),
        .alu_res_i     (alu_res)
    );

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000:  return a * b;
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            3'b111:  return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'b000) return 33;
        if (is_illegal(op)) return 1;
        if (b == 0) return 1;
        if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        if (op == 3'b100) return (a[31] ^ b[31]) ? 34 : 33;
        if (op == 3'b110) return a[31] ? 34 : 33;
        return 33;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check_output({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check_output({tag, "_resp_data"}, resp_data, 32'd0);
        check_output({tag, "_resp_illegal"}, {31'b0, resp_illegal}, 32'd0);
        check_output({tag, "_alu_busy"}, {31'b0, alu_busy}, 32'd0);
        check_output({tag, "_alu_sel"}, {28'b0, alu_sel}, {28'b0, ALU_ADD});
        check_output({tag, "_alu_a"}, alu_a, 32'd0);
        check_output({tag, "_alu_b"}, alu_b, 32'd0);
    endtask

    // Latency counts the acceptance edge as cycle 1; samples sit 1ns after each rising edge.
    task automatic wait_resp(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = alu_busy ? 1 : 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (alu_busy) busy_cycles++;
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output int busy_cycles);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(lat, busy_cycles);
    endtask

    task automatic complete_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_output(tag, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int busy_cycles);
        int lat;
        apply_stimulus(op, a, b, lat, busy_cycles);
        check_output({tag, "_lat"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check_output({tag, "_data"}, resp_data, ref_result(op, a, b));
        check_output({tag, "_illegal"}, {31'b0, resp_illegal}, {31'b0, is_illegal(op)});
        complete_resp({tag, "_ready"});
    endtask

    initial begin
        int          lat, busy, valid_seen, r;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_a      = '0;
        req_b      = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed multiply and divide");
        run_and_check("mul_7x6", 3'b000, 32'd7, 32'd6, busy);
        check_output("mul_busy_cycles", 32'(busy), 32'd32);
        run_and_check("mul_m1xm1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy);
        run_and_check("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, busy);
        check_output("div_fixup_busy", 32'(busy), 32'd33);
        run_and_check("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, busy);
        run_and_check("divu_100_7", 3'b101, 32'd100, 32'd7, busy);
        run_and_check("remu_100_7", 3'b111, 32'd100, 32'd7, busy);

        $display("[TB] special cases");
        run_and_check("divu_by0", 3'b101, 32'd5, 32'd0, busy);
        run_and_check("rem_by0", 3'b110, 32'd5, 32'd0, busy);
        run_and_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, busy);
        run_and_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, busy);
        run_and_check("illegal_001", 3'b001, 32'd9, 32'd3, busy);

        $display("[TB] backpressure and back-to-back");
        apply_stimulus(3'b000, 32'd3, 32'd5, lat, busy);
        check_output("bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_output("bp_valid", {31'b0, resp_valid}, 32'd1);
            check_output("bp_data", resp_data, 32'd15);
            check_output("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_output("bp_release_ready", {31'b0, req_ready}, 32'd1);
        check_output("bp_release_valid", {31'b0, resp_valid}, 32'd0);
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 32'd2;
        req_b     = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("b2b_accepted_busy", {31'b0, alu_busy}, 32'd1);
        wait_resp(lat, busy);
        check_output("b2b_lat", 32'(lat), 32'd33);
        check_output("b2b_data", resp_data, 32'd18);
        complete_resp("b2b_ready");

        $display("[TB] flush mid-iteration");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b101;
        req_a     = 32'd1_000_000;
        req_b     = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_output("flush_ready", {31'b0, req_ready}, 32'd1);
        check_output("flush_busy", {31'b0, alu_busy}, 32'd0);
        check_output("flush_valid", {31'b0, resp_valid}, 32'd0);
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) valid_seen++;
        end
        check_output("flush_no_resp", 32'(valid_seen), 32'd0);

        $display("[TB] asynchronous reset mid-iteration");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 32'd123;
        req_b     = 32'd456;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("after_rst", 3'b111, 32'd1000, 32'd7, busy);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 10);
            if (r == 10) op = 3'($urandom_range(1, 3));
            else op = op_list[r % 5];
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            run_and_check("rand", op, a, b, busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
